victim_miss_sequencer: RTL and testbench

//  Sequences L1 misses through the 4-entry, 256-bit-line victim cache and the memory port.

---
 rtl/victim_miss_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_victim_miss_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/victim_miss_sequencer.sv
// Sequences one L1 miss at a time: victim probe, optional memory read, line return to L1,
// install of the L1-evicted line, and write-back of whatever that install displaced.
module victim_miss_sequencer #(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 256,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              evict_valid,
    input  logic [ADDR_W-1:0] evict_addr,
    input  logic [LINE_W-1:0] evict_data,
    output logic              vc_lookup,
    output logic [ADDR_W-1:0] vc_addr,
    input  logic              vc_hit,
    input  logic [LINE_W-1:0] vc_line,
    output logic              vc_fill_valid,
    output logic [ADDR_W-1:0] vc_fill_addr,
    output logic [LINE_W-1:0] vc_fill_data,
    input  logic              vc_wb_valid,
    input  logic [ADDR_W-1:0] vc_wb_addr,
    input  logic [LINE_W-1:0] vc_wb_data,
    output logic              mem_req_valid,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [LINE_W-1:0] mem_req_data,
    input  logic              mem_req_ready,
    input  logic              mem_rsp_valid,
    input  logic [LINE_W-1:0] mem_rsp_data,
    output logic              rsp_valid,
    output logic [LINE_W-1:0] rsp_data,
    output logic              rsp_src,
    output logic              rsp_err,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    localparam int OFF_W = $clog2(LINE_W / 8);
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'({OFF_W{1'b1}});
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [LINE_W-1:0] LINE_ZERO = {LINE_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [TO_W-1:0]   TO_ZERO  = {TO_W{1'b0}};
    localparam logic [TO_W-1:0]   TO_ONE   = {{(TO_W-1){1'b0}}, 1'b1};
    localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PROBE   = 3'd1,
        MEMRD   = 3'd2,
        MEMWAIT = 3'd3,
        RESP    = 3'd4,
        FILL    = 3'd5,
        WB      = 3'd6
    } stateT;

    function automatic logic [ADDR_W-1:0] lineAlign(input logic [ADDR_W-1:0] addr);
        return addr & ~OFF_MASK;
    endfunction

    stateT             stateR, stateNext;
    logic [TO_W-1:0]   toCntR, toCntNext;
    logic [ADDR_W-1:0] reqAddrR, reqAddrNext;
    logic              evictValidR, evictValidNext;
    logic [ADDR_W-1:0] evictAddrR, evictAddrNext;
    logic [LINE_W-1:0] evictDataR, evictDataNext;
    logic [CNT_W-1:0]  hitCntNext, missCntNext;

    logic              reqReadyNext, vcLookupNext, fillValidNext;
    logic [ADDR_W-1:0] vcAddrNext, fillAddrNext;
    logic [LINE_W-1:0] fillDataNext;
    logic              memValidNext, memWeNext;
    logic [ADDR_W-1:0] memAddrNext;
    logic [LINE_W-1:0] memDataNext;
    logic              rspValidNext, rspSrcNext, rspErrNext;
    logic [LINE_W-1:0] rspDataNext;

    // Next-state, capture and next-output decode
    always_comb begin
        stateNext      = stateR;
        toCntNext      = TO_ZERO;
        reqAddrNext    = reqAddrR;
        evictValidNext = evictValidR;
        evictAddrNext  = evictAddrR;
        evictDataNext  = evictDataR;
        hitCntNext     = hit_cnt;
        missCntNext    = miss_cnt;
        rspDataNext    = LINE_ZERO;
        rspSrcNext     = 1'b0;
        rspErrNext     = 1'b0;

        case (stateR)
            IDLE: begin
                if (req_valid) begin
                    stateNext      = PROBE;
                    reqAddrNext    = lineAlign(req_addr);
                    evictValidNext = evict_valid;
                    evictAddrNext  = lineAlign(evict_addr);
                    evictDataNext  = evict_data;
                end else begin
                    stateNext = IDLE;
                end
            end
            PROBE: begin
                if (vc_hit) begin
                    stateNext   = RESP;
                    rspDataNext = vc_line;
                    rspSrcNext  = 1'b1;
                    hitCntNext  = (hit_cnt != CNT_MAX) ? hit_cnt + CNT_ONE : hit_cnt;
                end else begin
                    stateNext   = MEMRD;
                    missCntNext = (miss_cnt != CNT_MAX) ? miss_cnt + CNT_ONE : miss_cnt;
                end
            end
            MEMRD: begin
                stateNext = mem_req_ready ? MEMWAIT : MEMRD;
            end
            MEMWAIT: begin
                // The counter stays at zero outside this state, so entry always starts a fresh wait
                if (mem_rsp_valid) begin
                    stateNext   = RESP;
                    rspDataNext = mem_rsp_data;
                end else if (toCntR == TO_LAST) begin
                    stateNext  = RESP;
                    rspErrNext = 1'b1;
                end else begin
                    toCntNext = toCntR + TO_ONE;
                end
            end
            RESP: begin
                stateNext = evictValidR ? FILL : IDLE;
            end
            FILL: begin
                stateNext = vc_wb_valid ? WB : IDLE;
            end
            WB: begin
                stateNext = mem_req_ready ? IDLE : WB;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        reqReadyNext  = (stateNext == IDLE);
        vcLookupNext  = (stateNext == PROBE);
        vcAddrNext    = (stateNext == PROBE) ? reqAddrNext : ADDR_ZERO;
        fillValidNext = (stateNext == FILL);
        fillAddrNext  = (stateNext == FILL) ? evictAddrR : ADDR_ZERO;
        fillDataNext  = (stateNext == FILL) ? evictDataR : LINE_ZERO;
        rspValidNext  = (stateNext == RESP);

        case (stateNext)
            MEMRD: begin
                memValidNext = 1'b1;
                memWeNext    = 1'b0;
                memAddrNext  = reqAddrR;
                memDataNext  = LINE_ZERO;
            end
            WB: begin
                // The displaced line is only presented during FILL; hold it from the outputs after that
                memValidNext = 1'b1;
                memWeNext    = 1'b1;
                memAddrNext  = (stateR == FILL) ? lineAlign(vc_wb_addr) : mem_req_addr;
                memDataNext  = (stateR == FILL) ? vc_wb_data : mem_req_data;
            end
            default: begin
                memValidNext = 1'b0;
                memWeNext    = 1'b0;
                memAddrNext  = ADDR_ZERO;
                memDataNext  = LINE_ZERO;
            end
        endcase
    end

    // State, captured request and registered outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stateR        <= IDLE;
            toCntR        <= TO_ZERO;
            reqAddrR      <= ADDR_ZERO;
            evictValidR   <= 1'b0;
            evictAddrR    <= ADDR_ZERO;
            evictDataR    <= LINE_ZERO;
            hit_cnt       <= {CNT_W{1'b0}};
            miss_cnt      <= {CNT_W{1'b0}};
            req_ready     <= 1'b1;
            vc_lookup     <= 1'b0;
            vc_addr       <= ADDR_ZERO;
            vc_fill_valid <= 1'b0;
            vc_fill_addr  <= ADDR_ZERO;
            vc_fill_data  <= LINE_ZERO;
            mem_req_valid <= 1'b0;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= ADDR_ZERO;
            mem_req_data  <= LINE_ZERO;
            rsp_valid     <= 1'b0;
            rsp_data      <= LINE_ZERO;
            rsp_src       <= 1'b0;
            rsp_err       <= 1'b0;
        end else begin
            stateR        <= stateNext;
            toCntR        <= toCntNext;
            reqAddrR      <= reqAddrNext;
            evictValidR   <= evictValidNext;
            evictAddrR    <= evictAddrNext;
            evictDataR    <= evictDataNext;
            hit_cnt       <= hitCntNext;
            miss_cnt      <= missCntNext;
            req_ready     <= reqReadyNext;
            vc_lookup     <= vcLookupNext;
            vc_addr       <= vcAddrNext;
            vc_fill_valid <= fillValidNext;
            vc_fill_addr  <= fillAddrNext;
            vc_fill_data  <= fillDataNext;
            mem_req_valid <= memValidNext;
            mem_req_we    <= memWeNext;
            mem_req_addr  <= memAddrNext;
            mem_req_data  <= memDataNext;
            rsp_valid     <= rspValidNext;
            rsp_data      <= rspDataNext;
            rsp_src       <= rspSrcNext;
            rsp_err       <= rspErrNext;
        end
    end

endmodule

// File: tb/tb_victim_miss_sequencer.sv
// Directed bench for victim_miss_sequencer: hit path, memory path, evict/write-back ordering,
// back-pressure, timeout and mid-operation reset.
module tb_victim_miss_sequencer;

    localparam int ADDR_W  = 32;
    localparam int LINE_W  = 256;
    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 1023;

    localparam logic [LINE_W-1:0] LINE_AB = {32{8'hAB}};
    localparam logic [LINE_W-1:0] LINE_55 = {32{8'h55}};
    localparam logic [LINE_W-1:0] LINE_33 = {32{8'h33}};
    localparam logic [LINE_W-1:0] LINE_EE = {32{8'hEE}};
    localparam logic [LINE_W-1:0] LINE_77 = {32{8'h77}};
    localparam logic [LINE_W-1:0] LINE_C3 = {32{8'hC3}};
    localparam logic [LINE_W-1:0] LINE_FF = {32{8'hFF}};

    logic              CLK = 1'b0;
    logic              RST_N;
    logic              req_valid, req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              evict_valid;
    logic [ADDR_W-1:0] evict_addr;
    logic [LINE_W-1:0] evict_data;
    logic              vc_lookup;
    logic [ADDR_W-1:0] vc_addr;
    logic              vc_hit;
    logic [LINE_W-1:0] vc_line;
    logic              vc_fill_valid;
    logic [ADDR_W-1:0] vc_fill_addr;
    logic [LINE_W-1:0] vc_fill_data;
    logic              vc_wb_valid;
    logic [ADDR_W-1:0] vc_wb_addr;
    logic [LINE_W-1:0] vc_wb_data;
    logic              mem_req_valid, mem_req_we;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [LINE_W-1:0] mem_req_data;
    logic              mem_req_ready, mem_rsp_valid;
    logic [LINE_W-1:0] mem_rsp_data;
    logic              rsp_valid;
    logic [LINE_W-1:0] rsp_data;
    logic              rsp_src, rsp_err;
    logic [CNT_W-1:0]  hit_cnt, miss_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    victim_miss_sequencer #(
        .ADDR_W(ADDR_W), .LINE_W(LINE_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK(CLK), .RST_N(RST_N),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .evict_valid(evict_valid), .evict_addr(evict_addr), .evict_data(evict_data),
        .vc_lookup(vc_lookup), .vc_addr(vc_addr), .vc_hit(vc_hit), .vc_line(vc_line),
        .vc_fill_valid(vc_fill_valid), .vc_fill_addr(vc_fill_addr), .vc_fill_data(vc_fill_data),
        .vc_wb_valid(vc_wb_valid), .vc_wb_addr(vc_wb_addr), .vc_wb_data(vc_wb_data),
        .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
        .mem_req_data(mem_req_data), .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_src(rsp_src), .rsp_err(rsp_err),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    task automatic idle_inputs();
        req_valid = 1'b0; req_addr = 32'h0; evict_valid = 1'b0; evict_addr = 32'h0;
        evict_data = LINE_ZERO_F(); vc_hit = 1'b0; vc_line = LINE_ZERO_F();
        vc_wb_valid = 1'b0; vc_wb_addr = 32'h0; vc_wb_data = LINE_ZERO_F();
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = LINE_ZERO_F();
    endtask

    function automatic logic [LINE_W-1:0] LINE_ZERO_F();
        return {LINE_W{1'b0}};
    endfunction

    // Presents a request at a negedge; the following posedge is the accept edge (cycle 0).
    task automatic start_req(input logic [ADDR_W-1:0] addr, input logic ev,
                             input logic [ADDR_W-1:0] ev_addr, input logic [LINE_W-1:0] ev_data);
        @(negedge CLK);
        req_valid = 1'b1; req_addr = addr;
        evict_valid = ev; evict_addr = ev_addr; evict_data = ev_data;
    endtask

    task automatic test_reset();
        idle_inputs();
        RST_N = 1'b0;
        #12;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
        checks++; if (vc_lookup !== 1'b0) begin failures++; $display("FAIL reset_vc_lookup: got %b expected 0", vc_lookup); end
        checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_mem_req_valid: got %b expected 0", mem_req_valid); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        checks++; if (vc_fill_valid !== 1'b0) begin failures++; $display("FAIL reset_fill_valid: got %b expected 0", vc_fill_valid); end
        checks++; if (hit_cnt !== 16'd0) begin failures++; $display("FAIL reset_hit_cnt: got %0d expected 0", hit_cnt); end
        checks++; if (miss_cnt !== 16'd0) begin failures++; $display("FAIL reset_miss_cnt: got %0d expected 0", miss_cnt); end
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL post_reset_ready: got %b expected 1", req_ready); end
    endtask

    task automatic test_victim_hit();
        logic mem_seen = 1'b0;
        vc_hit = 1'b1; vc_line = LINE_AB;
        start_req(32'h0000_1234, 1'b0, 32'h0, LINE_ZERO_F());
        for (int c = 1; c <= 3; c++) begin
            @(negedge CLK);
            req_valid = 1'b0;
            if (mem_req_valid) mem_seen = 1'b1;
            if (c == 1) begin
                checks++; if (vc_lookup !== 1'b1) begin failures++; $display("FAIL hit_lookup: got %b expected 1", vc_lookup); end
                checks++; if (vc_addr !== 32'h0000_1220) begin failures++; $display("FAIL hit_vc_addr: got %h expected 00001220", vc_addr); end
                checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL hit_busy: got %b expected 0", req_ready); end
            end else if (c == 2) begin
                checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL hit_rsp_valid: got %b expected 1", rsp_valid); end
                checks++; if (rsp_src !== 1'b1) begin failures++; $display("FAIL hit_rsp_src: got %b expected 1", rsp_src); end
                checks++; if (rsp_data !== LINE_AB) begin failures++; $display("FAIL hit_rsp_data: got %h expected %h", rsp_data, LINE_AB); end
                checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL hit_rsp_err: got %b expected 0", rsp_err); end
                checks++; if (hit_cnt !== 16'd1) begin failures++; $display("FAIL hit_cnt: got %0d expected 1", hit_cnt); end
            end else begin
                checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL hit_rsp_one_cycle: got %b expected 0", rsp_valid); end
                checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL hit_back_idle: got %b expected 1", req_ready); end
            end
        end
        vc_hit = 1'b0;
        checks++; if (mem_seen !== 1'b0) begin failures++; $display("FAIL hit_no_mem: got %b expected 0", mem_seen); end
    endtask

    task automatic test_mem_read();
        mem_req_ready = 1'b1;
        start_req(32'h0000_ABCD, 1'b0, 32'h0, LINE_ZERO_F());
        for (int c = 1; c <= 7; c++) begin
            @(negedge CLK);
            req_valid = 1'b0;
            mem_rsp_valid = 1'b0;
            if (c == 1) begin
                checks++; if (vc_lookup !== 1'b1) begin failures++; $display("FAIL miss_lookup: got %b expected 1", vc_lookup); end
                mem_rsp_valid = 1'b1; mem_rsp_data = LINE_FF;  // stray, must be ignored
            end else if (c == 2) begin
                checks++; if (mem_req_valid !== 1'b1) begin failures++; $display("FAIL miss_rd_valid: got %b expected 1", mem_req_valid); end
                checks++; if (mem_req_we !== 1'b0) begin failures++; $display("FAIL miss_rd_we: got %b expected 0", mem_req_we); end
                checks++; if (mem_req_addr !== 32'h0000_ABC0) begin failures++; $display("FAIL miss_rd_addr: got %h expected 0000abc0", mem_req_addr); end
            end else if (c >= 3 && c <= 5) begin
                checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL miss_early_rsp: got %b expected 0 at cycle %0d", rsp_valid, c); end
                if (c == 3) begin
                    checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL miss_rd_drop: got %b expected 0", mem_req_valid); end
                end
                if (c == 5) begin mem_rsp_valid = 1'b1; mem_rsp_data = LINE_55; end
            end else if (c == 6) begin
                checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL miss_rsp_valid: got %b expected 1", rsp_valid); end
                checks++; if (rsp_src !== 1'b0) begin failures++; $display("FAIL miss_rsp_src: got %b expected 0", rsp_src); end
                checks++; if (rsp_data !== LINE_55) begin failures++; $display("FAIL miss_rsp_data: got %h expected %h", rsp_data, LINE_55); end
                checks++; if (miss_cnt !== 16'd1) begin failures++; $display("FAIL miss_cnt: got %0d expected 1", miss_cnt); end
                checks++; if (hit_cnt !== 16'd1) begin failures++; $display("FAIL miss_hit_cnt: got %0d expected 1", hit_cnt); end
            end else begin
                checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL miss_back_idle: got %b expected 1", req_ready); end
            end
        end
    endtask

    task automatic test_evict_wb();
        mem_req_ready = 1'b1;
        start_req(32'h0000_3000, 1'b1, 32'h0000_101F, LINE_EE);
        for (int c = 1; c <= 7; c++) begin
            @(negedge CLK);
            req_valid = 1'b0; mem_rsp_valid = 1'b0; vc_wb_valid = 1'b0;
            if (c == 2) begin
                checks++; if (mem_req_valid !== 1'b1 || mem_req_we !== 1'b0 || mem_req_addr !== 32'h0000_3000) begin
                    failures++; $display("FAIL ev_read: got v=%b we=%b a=%h expected v=1 we=0 a=00003000", mem_req_valid, mem_req_we, mem_req_addr); end
            end else if (c == 3) begin
                checks++; if (vc_fill_valid !== 1'b0) begin failures++; $display("FAIL ev_early_fill: got %b expected 0", vc_fill_valid); end
                mem_rsp_valid = 1'b1; mem_rsp_data = LINE_33;
            end else if (c == 4) begin
                checks++; if (rsp_valid !== 1'b1 || rsp_data !== LINE_33) begin
                    failures++; $display("FAIL ev_rsp: got v=%b d=%h expected v=1 d=%h", rsp_valid, rsp_data, LINE_33); end
                checks++; if (vc_fill_valid !== 1'b0) begin failures++; $display("FAIL ev_fill_before_rsp: got %b expected 0", vc_fill_valid); end
            end else if (c == 5) begin
                checks++; if (vc_fill_valid !== 1'b1) begin failures++; $display("FAIL ev_fill_valid: got %b expected 1", vc_fill_valid); end
                checks++; if (vc_fill_addr !== 32'h0000_1000) begin failures++; $display("FAIL ev_fill_addr: got %h expected 00001000", vc_fill_addr); end
                checks++; if (vc_fill_data !== LINE_EE) begin failures++; $display("FAIL ev_fill_data: got %h expected %h", vc_fill_data, LINE_EE); end
                checks++; if (rsp_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
                    failures++; $display("FAIL ev_fill_alone: got rsp=%b mem=%b expected 0 0", rsp_valid, mem_req_valid); end
                vc_wb_valid = 1'b1; vc_wb_addr = 32'h0000_2005; vc_wb_data = LINE_77;
            end else if (c == 6) begin
                checks++; if (mem_req_valid !== 1'b1 || mem_req_we !== 1'b1) begin
                    failures++; $display("FAIL ev_wb_strobe: got v=%b we=%b expected 1 1", mem_req_valid, mem_req_we); end
                checks++; if (mem_req_addr !== 32'h0000_2000) begin failures++; $display("FAIL ev_wb_addr: got %h expected 00002000", mem_req_addr); end
                checks++; if (mem_req_data !== LINE_77) begin failures++; $display("FAIL ev_wb_data: got %h expected %h", mem_req_data, LINE_77); end
                checks++; if (vc_fill_valid !== 1'b0) begin failures++; $display("FAIL ev_fill_one_cycle: got %b expected 0", vc_fill_valid); end
            end else if (c == 7) begin
                checks++; if (mem_req_valid !== 1'b0 || req_ready !== 1'b1) begin
                    failures++; $display("FAIL ev_back_idle: got mem=%b ready=%b expected 0 1", mem_req_valid, req_ready); end
                checks++; if (miss_cnt !== 16'd2) begin failures++; $display("FAIL ev_miss_cnt: got %0d expected 2", miss_cnt); end
            end
        end
    endtask

    task automatic test_fill_no_wb();
        logic mem_seen = 1'b0;
        vc_hit = 1'b1; vc_line = LINE_AB;
        vc_wb_addr = 32'h0000_9990; vc_wb_data = LINE_FF;
        start_req(32'h0000_0040, 1'b1, 32'h0000_5A5F, LINE_C3);
        for (int c = 1; c <= 4; c++) begin
            @(negedge CLK);
            req_valid = 1'b0;
            if (mem_req_valid) mem_seen = 1'b1;
            if (c == 2) begin
                vc_hit = 1'b0;
                checks++; if (rsp_valid !== 1'b1 || rsp_src !== 1'b1) begin
                    failures++; $display("FAIL nowb_rsp: got v=%b src=%b expected 1 1", rsp_valid, rsp_src); end
                checks++; if (hit_cnt !== 16'd2) begin failures++; $display("FAIL nowb_hit_cnt: got %0d expected 2", hit_cnt); end
            end else if (c == 3) begin
                checks++; if (vc_fill_valid !== 1'b1 || vc_fill_addr !== 32'h0000_5A40 || vc_fill_data !== LINE_C3) begin
                    failures++; $display("FAIL nowb_fill: got v=%b a=%h expected v=1 a=00005a40", vc_fill_valid, vc_fill_addr); end
            end else if (c == 4) begin
                checks++; if (req_ready !== 1'b1 || vc_fill_valid !== 1'b0) begin
                    failures++; $display("FAIL nowb_idle: got ready=%b fill=%b expected 1 0", req_ready, vc_fill_valid); end
            end
        end
        checks++; if (mem_seen !== 1'b0) begin failures++; $display("FAIL nowb_no_mem: got %b expected 0", mem_seen); end
    endtask

    task automatic test_backpressure();
        mem_req_ready = 1'b0;
        start_req(32'h4444_4444, 1'b0, 32'h0, LINE_ZERO_F());
        for (int c = 1; c <= 15; c++) begin
            @(negedge CLK);
            req_valid = 1'b0; mem_rsp_valid = 1'b0;
            if (c >= 2 && c <= 12) begin
                checks++; if (mem_req_valid !== 1'b1 || mem_req_we !== 1'b0 || mem_req_addr !== 32'h4444_4440 || req_ready !== 1'b0) begin
                    failures++; $display("FAIL bp_hold: cycle %0d got v=%b we=%b a=%h rdy=%b expected 1 0 44444440 0",
                                         c, mem_req_valid, mem_req_we, mem_req_addr, req_ready); end
                if (c == 12) mem_req_ready = 1'b1;
            end else if (c == 13) begin
                mem_req_ready = 1'b0;
                checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL bp_release: got %b expected 0", mem_req_valid); end
                mem_rsp_valid = 1'b1; mem_rsp_data = LINE_55;
            end else if (c == 14) begin
                checks++; if (rsp_valid !== 1'b1 || rsp_data !== LINE_55) begin
                    failures++; $display("FAIL bp_rsp: got v=%b d=%h expected 1 %h", rsp_valid, rsp_data, LINE_55); end
            end else if (c == 15) begin
                checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL bp_idle: got %b expected 1", req_ready); end
            end
        end
    endtask

    task automatic test_timeout();
        int first_rsp = 0;
        logic err_s = 1'b0, src_s = 1'b1;
        logic [LINE_W-1:0] data_s = LINE_FF;
        mem_req_ready = 1'b1; mem_rsp_data = LINE_C3;
        start_req(32'h0000_6000, 1'b0, 32'h0, LINE_ZERO_F());
        for (int c = 1; c <= TIMEOUT + 10 && first_rsp == 0; c++) begin
            @(negedge CLK);
            req_valid = 1'b0;
            if (rsp_valid) begin first_rsp = c; err_s = rsp_err; src_s = rsp_src; data_s = rsp_data; end
        end
        mem_req_ready = 1'b0;
        checks++; if (first_rsp < TIMEOUT + 2 || first_rsp > TIMEOUT + 4) begin
            failures++; $display("FAIL to_latency: got cycle %0d expected %0d..%0d (0 = never)", first_rsp, TIMEOUT + 2, TIMEOUT + 4); end
        checks++; if (err_s !== 1'b1) begin failures++; $display("FAIL to_err: got %b expected 1", err_s); end
        checks++; if (data_s !== LINE_ZERO_F()) begin failures++; $display("FAIL to_data: got %h expected 0", data_s); end
        checks++; if (src_s !== 1'b0) begin failures++; $display("FAIL to_src: got %b expected 0", src_s); end
        checks++; if (miss_cnt !== 16'd4) begin failures++; $display("FAIL to_miss_cnt: got %0d expected 4", miss_cnt); end
        @(negedge CLK);
        checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            failures++; $display("FAIL to_idle: got ready=%b rsp=%b expected 1 0", req_ready, rsp_valid); end
    endtask

    task automatic test_reset_midop();
        mem_req_ready = 1'b1;
        start_req(32'h0000_7000, 1'b1, 32'h0000_8000, LINE_EE);
        for (int c = 1; c <= 3; c++) begin
            @(negedge CLK);
            req_valid = 1'b0;
        end
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL rst_busy_before: got %b expected 0", req_ready); end
        RST_N = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = LINE_55;
        #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_ready: got %b expected 1", req_ready); end
        checks++; if (mem_req_valid !== 1'b0 || rsp_valid !== 1'b0 || vc_lookup !== 1'b0 || vc_fill_valid !== 1'b0) begin
            failures++; $display("FAIL rst_mid_strobes: got mem=%b rsp=%b lk=%b fill=%b expected 0", mem_req_valid, rsp_valid, vc_lookup, vc_fill_valid); end
        checks++; if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0) begin
            failures++; $display("FAIL rst_mid_cnt: got hit=%0d miss=%0d expected 0 0", hit_cnt, miss_cnt); end
        @(negedge CLK);
        RST_N = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge CLK);
            checks++; if (rsp_valid !== 1'b0 || vc_fill_valid !== 1'b0 || req_ready !== 1'b1) begin
                failures++; $display("FAIL rst_quiet: cycle %0d got rsp=%b fill=%b ready=%b expected 0 0 1", c, rsp_valid, vc_fill_valid, req_ready); end
        end
        mem_rsp_valid = 1'b0;
        vc_hit = 1'b1; vc_line = LINE_AB;
        start_req(32'h0000_0100, 1'b0, 32'h0, LINE_ZERO_F());
        for (int c = 1; c <= 2; c++) begin
            @(negedge CLK);
            req_valid = 1'b0;
        end
        vc_hit = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || rsp_src !== 1'b1 || rsp_data !== LINE_AB) begin
            failures++; $display("FAIL rst_new_req: got v=%b src=%b expected 1 1", rsp_valid, rsp_src); end
        checks++; if (hit_cnt !== 16'd1) begin failures++; $display("FAIL rst_new_hit_cnt: got %0d expected 1", hit_cnt); end
    endtask

    initial begin
        test_reset();
        test_victim_hit();
        test_mem_read();
        test_evict_wb();
        test_fill_no_wb();
        test_backpressure();
        test_timeout();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
